rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//   Shares the single register-file write port between the in-order pipeline writeback
//   (WB) and one long-latency unit (LU, e.g. divider/multicycle load).
//   Keeps a busy scoreboard of x1..x31 whose LU results are outstanding, for issue-stage
//   hazard checks. Sits between WB/LU and the regfile; drives the regfile write port and stallW.
// PARAMETERS
//   XLEN      64  data width
//   MAX_WAIT  4   LU-blocked cycles before LU is forced ahead of WB (0 = LU always wins)
// PORTS
//   clk           in   1     clock; all state updates on posedge
//   rst           in   1     reset, asynchronous, active-low (0 = reset)
//   wb_valid      in   1     pipeline result present in WB this cycle
//   wb_addr       in   5     WB destination register
//   wb_data       in   XLEN  WB result
//   lu_valid      in   1     LU result waiting; held with addr/data stable until lu_ready
//   lu_addr       in   5     LU destination register
//   lu_data       in   XLEN  LU result
//   lu_ready      out  1     LU result written this cycle (handshake completes)
//   iss_valid     in   1     an LU op issues this cycle with destination iss_rd
//   iss_rd        in   5     destination of issuing LU op
//   chk_rs1       in   5     issue-stage source 1 to check
//   chk_rs2       in   5     issue-stage source 2 to check
//   chk_rd        in   5     issue-stage destination to check
//   rs1_busy      out  1     busy[chk_rs1]
//   rs2_busy      out  1     busy[chk_rs2]
//   rd_busy       out  1     busy[chk_rd]
//   iss_conflict  out  1     iss_valid & busy[iss_rd] (issue logic error)
//   lu_idle       out  1     no register busy
//   stall_wb      out  1     WB must hold this cycle (drives regfile stallW / pipeline stall)
//   rf_we         out  1     regfile write enable
//   rf_waddr      out  5     regfile write address
//   rf_wdata      out  XLEN  regfile write data
//   waw_err       out  1     sticky: WB wrote a register that was busy
// BEHAVIOUR
//   State: busy[31:1] (busy[0] constant 0), wait_cnt (saturating, width clog2(MAX_WAIT+1)),
//   waw_err flag. Reset (rst=0, async): busy=0, wait_cnt=0, waw_err=0.
//   All other outputs are combinational from state + inputs; during reset they evaluate
//   to 0 except lu_idle=1.
//   Arbitration (combinational):
//   - starve  = (wait_cnt >= MAX_WAIT)
//   - grant_lu = lu_valid & (~wb_valid | starve)
//   - lu_ready = grant_lu
//   - stall_wb = wb_valid & grant_lu
//   - Write port: if grant_lu, addr/data = lu_*; else addr/data = wb_*.
//     rf_we = (grant_lu | wb_valid) & (selected addr != 0).
//     The grant is still consumed on an x0 write; rf_we stays 0.
//   - A stalled WB holds wb_* stable; it wins next cycle unless LU is still starved.
//   wait_cnt:
//   - 0 when ~lu_valid or grant_lu.
//   - Otherwise +1, saturating at MAX_WAIT.
//   - Worst-case LU wait is MAX_WAIT+1 cycles; WB stalls at most 1 cycle per LU result.
//   Scoreboard, next-state per posedge:
//   - Clear busy[lu_addr] on grant_lu.
//   - Set busy[iss_rd] on iss_valid & iss_rd!=0.
//   - Set and clear on the same addr in the same cycle: set wins.
//   - Check outputs read the registered busy vector; a clear is visible the cycle after grant.
//   - iss_valid on an already-busy reg: iss_conflict=1 that cycle; busy stays 1.
//   waw_err: set on posedge when wb_valid & ~grant_lu & wb_addr!=0 & busy[wb_addr];
//     cleared only by reset.
//   lu_idle = (busy == 0).
// TESTING
//   1 Reset release, wb_valid=1 addr=5 data=0xAA
//     -> rf_we=1 waddr=5 wdata=0xAA stall_wb=0 lu_ready=0.
//   2 iss_valid rd=7; 3 cycles later lu_valid addr=7 data=0x1234, wb idle
//     -> lu_ready=1 same cycle, rf_we waddr=7; rs1_busy(7)=1 until the cycle after grant, then 0.
//   3 MAX_WAIT=4, wb_valid held 1, lu_valid=1 from t0
//     -> LU granted at t4, stall_wb=1 at t4 only, wait_cnt back to 0.
//   4 Same cycle: lu_valid addr=9 granted and iss_valid rd=9 -> busy[9] remains 1 next cycle.
//   5 lu_valid addr=0 -> lu_ready=1, rf_we=0; wb_valid addr=3 with busy[3]=1 -> waw_err=1 sticky.
//   6 Assert rst mid-wait (busy nonzero, wait_cnt=2)
//     -> immediately lu_idle=1, all busy=0, rf_we=0, lu_ready=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and one long-latency unit,
// with a busy scoreboard of LU destinations for issue-stage hazard checks.
module rf_wb_arbiter #(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lu_valid,
  input  logic [4:0]      lu_addr,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  output logic            iss_conflict,
  output logic            lu_idle,
  output logic            stall_wb,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            waw_err
);

  localparam int            CW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [31:1]     busy_q, busy_d;
  logic [31:0]     busy_v;
  logic [CW-1:0]   wait_q, wait_d;
  logic            waw_q, waw_d;
  logic            starve, grant_lu;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;

  // x0 is never tracked, so reading index 0 always returns "not busy"
  assign busy_v = {busy_q, 1'b0};

  always_comb begin
    starve   = (wait_q >= WAIT_MAX);
    grant_lu = lu_valid & (~wb_valid | starve);
    sel_addr = grant_lu ? lu_addr : wb_addr;
    sel_data = grant_lu ? lu_data : wb_data;
  end

  // Outputs are forced quiet while reset is held, regardless of live inputs
  assign lu_ready     = rst & grant_lu;
  assign stall_wb     = rst & wb_valid & grant_lu;
  assign rf_we        = rst & (grant_lu | wb_valid) & (|sel_addr);
  assign rf_waddr     = rst ? sel_addr : '0;
  assign rf_wdata     = rst ? sel_data : '0;
  assign rs1_busy     = rst & busy_v[chk_rs1];
  assign rs2_busy     = rst & busy_v[chk_rs2];
  assign rd_busy      = rst & busy_v[chk_rd];
  assign iss_conflict = rst & iss_valid & busy_v[iss_rd];
  assign lu_idle      = ~rst | (busy_q == '0);
  assign waw_err      = waw_q;

  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < 32; i++) begin
      if (grant_lu && lu_addr == 5'(i)) busy_d[i] = 1'b0;
      // a new issue to the register being retired keeps it busy
      if (iss_valid && iss_rd == 5'(i)) busy_d[i] = 1'b1;
    end

    wait_d = wait_q;
    if (!lu_valid || grant_lu)  wait_d = '0;
    else if (wait_q < WAIT_MAX) wait_d = wait_q + 1'b1;

    waw_d = waw_q | (wb_valid & ~grant_lu & (|wb_addr) & busy_v[wb_addr]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      wait_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wait_q <= wait_d;
      waw_q  <= waw_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a behavioural scoreboard model.
module tb_rf_wb_arbiter;

  localparam int XLEN     = 64;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_valid, lu_valid, iss_valid;
  logic [4:0]      wb_addr, lu_addr, iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic [XLEN-1:0] wb_data, lu_data;
  logic            lu_ready, rs1_busy, rs2_busy, rd_busy, iss_conflict, lu_idle;
  logic            stall_wb, rf_we, waw_err;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  rf_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .iss_conflict(iss_conflict), .lu_idle(lu_idle), .stall_wb(stall_wb),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: set of outstanding LU destinations, consecutive blocked-cycle count
  bit [31:0] m_busy;
  int        m_blocked;
  bit        m_waw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_grant();
    return lu_valid && (!wb_valid || m_blocked >= MAX_WAIT);
  endfunction

  task automatic model_reset();
    m_busy = '0; m_blocked = 0; m_waw = 0;
  endtask

  task automatic check_all();
    bit g, we;
    logic [4:0] a;
    logic [XLEN-1:0] d;
    g = m_grant();
    a = g ? lu_addr : wb_addr;
    d = g ? lu_data : wb_data;
    we = (g || wb_valid) && a != 0;
    if (!rst) begin g = 0; we = 0; a = '0; d = '0; end
    chk("lu_ready", lu_ready, g);
    chk("stall_wb", stall_wb, g && wb_valid);
    chk("rf_we", rf_we, we);
    chk("rf_waddr", rf_waddr, a);
    chk("rf_wdata", rf_wdata, d);
    chk("rs1_busy", rs1_busy, rst && m_busy[chk_rs1]);
    chk("rs2_busy", rs2_busy, rst && m_busy[chk_rs2]);
    chk("rd_busy", rd_busy, rst && m_busy[chk_rd]);
    chk("iss_conflict", iss_conflict, rst && iss_valid && m_busy[iss_rd]);
    chk("lu_idle", lu_idle, !rst || m_busy == 0);
    chk("waw_err", waw_err, m_waw);
  endtask

  task automatic model_update();
    bit g;
    if (!rst) begin model_reset(); return; end
    g = m_grant();
    if (wb_valid && !g && wb_addr != 0 && m_busy[wb_addr]) m_waw = 1;
    if (g) m_busy[lu_addr] = 0;
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
    m_busy[0] = 0;
    m_blocked = (!lu_valid || g) ? 0 : m_blocked + 1;
  endtask

  // One cycle: check outputs at negedge, advance the model at posedge, inputs free after
  task automatic step(output bit granted);
    @(negedge clk);
    check_all();
    granted = rst && m_grant();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    lu_valid = 0; lu_addr = '0; lu_data = '0;
    iss_valid = 0; iss_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
  endtask

  bit g;

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    wb_valid = 1; wb_addr = 5'd5; wb_data = 64'hAA; lu_valid = 1; lu_addr = 5'd6;
    #2;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_lu_ready", lu_ready, 0);
    chk("rst_lu_idle", lu_idle, 1);
    @(posedge clk); #1;
    rst = 1; lu_valid = 0;

    // 1: plain WB write after reset release
    #1;
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 64'hAA);
    chk("t1_stall", stall_wb, 0);
    step(g);
    idle_inputs();

    // 2: issue x7, retire it later, busy clears the cycle after the grant
    iss_valid = 1; iss_rd = 5'd7; chk_rs1 = 5'd7;
    step(g);
    iss_valid = 0;
    repeat (3) step(g);
    lu_valid = 1; lu_addr = 5'd7; lu_data = 64'h1234;
    #1;
    chk("t2_ready", lu_ready, 1);
    chk("t2_waddr", rf_waddr, 7);
    chk("t2_busy_at_grant", rs1_busy, 1);
    step(g);
    lu_valid = 0;
    #1;
    chk("t2_busy_after", rs1_busy, 0);
    step(g);

    // 3: WB held busy, LU forced through after MAX_WAIT blocked cycles
    wb_valid = 1; wb_addr = 5'd12; wb_data = 64'h55;
    lu_valid = 1; lu_addr = 5'd13; lu_data = 64'h77;
    for (int t = 0; t <= MAX_WAIT; t++) begin
      #1;
      chk("t3_ready", lu_ready, t == MAX_WAIT);
      chk("t3_stall", stall_wb, t == MAX_WAIT);
      step(g);
    end
    lu_valid = 0;
    #1;
    chk("t3_wb_resumes", rf_waddr, 12);
    chk("t3_no_stall", stall_wb, 0);
    step(g);
    idle_inputs();

    // 4: retire and reissue x9 in the same cycle
    iss_valid = 1; iss_rd = 5'd9;
    step(g);
    lu_valid = 1; lu_addr = 5'd9; lu_data = 64'h99; chk_rd = 5'd9;
    #1;
    chk("t4_conflict", iss_conflict, 1);
    step(g);
    idle_inputs(); chk_rd = 5'd9;
    #1;
    chk("t4_still_busy", rd_busy, 1);
    step(g);

    // 5: LU write to x0 consumes grant without writing; WB to busy x3 flags WAW
    lu_valid = 1; lu_addr = 5'd0; iss_valid = 1; iss_rd = 5'd3;
    #1;
    chk("t5_ready", lu_ready, 1);
    chk("t5_we", rf_we, 0);
    step(g);
    idle_inputs();
    wb_valid = 1; wb_addr = 5'd3; wb_data = 64'h3;
    step(g);
    wb_valid = 0;
    #1;
    chk("t5_waw", waw_err, 1);
    repeat (2) step(g);
    chk("t5_waw_sticky", waw_err, 1);

    // 6: async reset in the middle of an LU wait
    wb_valid = 1; wb_addr = 5'd20; lu_valid = 1; lu_addr = 5'd21;
    repeat (2) step(g);
    #2;
    rst = 0;
    model_reset();
    #1;
    chk("t6_idle", lu_idle, 1);
    chk("t6_we", rf_we, 0);
    chk("t6_ready", lu_ready, 0);
    chk("t6_waw", waw_err, 0);
    chk("t6_rd_busy", rd_busy, 0);
    step(g);
    rst = 1;
    idle_inputs();
    step(g);

    // Random traffic obeying the hold rules of both producers
    for (int c = 0; c < 3000; c++) begin
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd    = 5'($urandom);
      chk_rs1   = 5'($urandom);
      chk_rs2   = 5'($urandom);
      chk_rd    = 5'($urandom);
      if (!lu_valid && $urandom_range(0, 2) == 0) begin
        lu_valid = 1;
        lu_addr  = 5'($urandom);
        for (int k = 0; k < 8; k++) begin
          logic [4:0] r;
          r = 5'($urandom);
          if (m_busy[r]) begin lu_addr = r; break; end
        end
        lu_data = {$urandom, $urandom};
      end
      if (c == 1500) begin
        rst = 0; model_reset();
      end else if (c == 1502) begin
        rst = 1;
      end
      step(g);
      if (g) lu_valid = 0;
      if (!(g && wb_valid)) begin
        wb_valid = ($urandom_range(0, 2) != 0);
        wb_addr  = 5'($urandom);
        wb_data  = {$urandom, $urandom};
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
